// File: rtl/two_op_pkg.sv
// ---------------------------------------------------------------------------
// two_op_pkg
// Shared definitions for the two-port memory arbiter slice.
//   AW_DEF / DW_DEF : default address / data widths (16-bit words)
//   port_t          : response owner id (PORT_NONE / PORT_I / PORT_D)
//   arb_state_t     : arbiter ownership state (ARB_IDLE / ARB_LOCKED)
// Optional feature macro used by the files importing this package:
//   TWO_OP_ARB_RR_EN
// ---------------------------------------------------------------------------
package two_op_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef logic [1:0] port_t;

  localparam port_t PORT_NONE = 2'd0;
  localparam port_t PORT_I    = 2'd1;
  localparam port_t PORT_D    = 2'd2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage : two_op_pkg

// File: rtl/two_op_arb_pick.sv
// ---------------------------------------------------------------------------
// two_op_arb_pick
// Purely combinational grant picker for the fetch / data ports.
// Ports:
//   i_req, d_req : current requests from fetch and data ports
//   state        : ARB_LOCKED restricts grants to the data port
//   starved      : (fixed-priority build) fetch has waited the full limit
//   last_d       : (round-robin build) data port held the most recent grant
//   gnt          : one-hot-or-zero grant vector, [0]=fetch, [1]=data
// Macro TWO_OP_ARB_RR_EN selects round-robin arbitration in the idle state;
// otherwise fixed data-over-fetch priority with a starvation override.
// ---------------------------------------------------------------------------
module two_op_arb_pick
  import two_op_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_state_t state,
`ifdef TWO_OP_ARB_RR_EN
  input  logic       last_d,
`else
  input  logic       starved,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (state == ARB_LOCKED) begin
      // An atomic sequence owns the memory; fetch waits however long it has.
      gnt[1] = d_req;
    end else begin
`ifdef TWO_OP_ARB_RR_EN
      if (i_req && d_req) begin
        // Tie: whoever was served last yields.
        if (last_d) gnt[0] = 1'b1;
        else        gnt[1] = 1'b1;
      end else begin
        gnt[0] = i_req;
        gnt[1] = d_req;
      end
`else
      if (i_req && starved) gnt[0] = 1'b1;
      else if (d_req)       gnt[1] = 1'b1;
      else if (i_req)       gnt[0] = 1'b1;
`endif
    end
  end

endmodule : two_op_arb_pick

// File: rtl/two_op_mem_arbiter.sv
// ---------------------------------------------------------------------------
// two_op_mem_arbiter
// Shares one single-port synchronous memory (1-cycle registered read)
// between a read-only instruction-fetch port and a read/write data port.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt              : fetch request handshake
//   i_rdata/i_rvalid                : fetch response (cycle after i_gnt)
//   d_req/d_we/d_lock/d_addr/d_wdata: data request; d_lock keeps ownership
//   d_gnt                           : data access accepted
//   d_rdata/d_rvalid                : data read response (never for writes)
//   mem_en/mem_we/mem_addr/mem_wdata: memory command (combinational)
//   mem_rdata                       : memory read data, cycle after a read
// Macro TWO_OP_ARB_RR_EN: round-robin idle arbitration, no wait counter.
// Default build: data-over-fetch priority, fetch forced after STARVE_LIMIT
// consecutive waiting cycles.
// ---------------------------------------------------------------------------
module two_op_mem_arbiter
  import two_op_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state_reg, state_next;
  port_t      rsp_port_reg, rsp_port_next;
  logic [1:0] gnt;

  // -------------------------------------------------------------------------
  // Arbitration history: wait counter (fixed priority) or last winner (RR)
  // -------------------------------------------------------------------------
`ifdef TWO_OP_ARB_RR_EN
  logic last_d_reg, last_d_next;

  always_comb begin
    last_d_next = last_d_reg;
    if (|gnt) last_d_next = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_reg <= 1'b0;
    else        last_d_reg <= last_d_next;
  end

  two_op_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .state  (state_reg),
    .last_d (last_d_reg),
    .gnt    (gnt)
  );
`else
  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);

  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           starved;

  // Counter saturates at the limit, so equality is the same as >=.
  assign starved = (wait_cnt_reg == WAIT_MAX);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!i_req || gnt[0])          wait_cnt_next = '0;
    else if (wait_cnt_reg != WAIT_MAX) wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_reg <= '0;
    else        wait_cnt_reg <= wait_cnt_next;
  end

  two_op_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .state   (state_reg),
    .starved (starved),
    .gnt     (gnt)
  );
`endif

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // -------------------------------------------------------------------------
  // Memory command mux
  // -------------------------------------------------------------------------
  assign mem_en    = |gnt;
  assign mem_we    = gnt[1] & d_we;
  assign mem_addr  = gnt[1] ? d_addr : i_addr;
  assign mem_wdata = d_wdata;

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:   if (gnt[1] && d_lock) state_next = ARB_LOCKED;
      ARB_LOCKED: if (!d_lock)          state_next = ARB_IDLE;
      default:                          state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ARB_IDLE;
    else        state_reg <= state_next;
  end

  // -------------------------------------------------------------------------
  // Response pipe: remember which port issued the read this cycle
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_port_next = PORT_NONE;
    if (gnt[0])             rsp_port_next = PORT_I;
    else if (gnt[1] && !d_we) rsp_port_next = PORT_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_port_reg <= PORT_NONE;
    else        rsp_port_reg <= rsp_port_next;
  end

  assign i_rvalid = (rsp_port_reg == PORT_I);
  assign d_rvalid = (rsp_port_reg == PORT_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule : two_op_mem_arbiter
